// File: rtl/gradient_pkg.sv
// Shared types and default geometry for the gradient pipeline blocks
// (receiver, sequencer, transmitter).
package gradient_pkg;

  localparam int DEF_IMG_WIDTH  = 4096;
  localparam int DEF_IMG_HEIGHT = 3072;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOF = 3'd1,
    S_RECEIVE  = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

endpackage

// File: rtl/gradient_frame_sequencer_if.sv
// Stream handshake seen by the frame sequencer: input stream (gated by tready)
// and the transmitter's output stream (monitored only).
interface gradient_frame_sequencer_if;

  logic s_axis_tvalid;
  logic s_axis_tuser;
  logic s_axis_tlast;
  logic o_s_axis_tready;
  logic m_axis_tvalid;
  logic m_axis_tlast;

  modport master (
    output s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output m_axis_tvalid, m_axis_tlast,
    input  o_s_axis_tready
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  m_axis_tvalid, m_axis_tlast,
    output o_s_axis_tready
  );

endinterface

// File: rtl/gradient_geom_checker.sv
// Pixel/line position tracking for the input stream; flags misplaced tlast
// or a mid-frame tuser and reports the last pixel of the frame.
module gradient_geom_checker
  import gradient_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int CNT_W      = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_beat,
  input  logic i_in_wait_sof,
  input  logic i_in_receive,
  input  logic i_tuser,
  input  logic i_tlast,
  output logic o_frame_end,
  output logic o_geom_err
);

  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic             w_active;
  logic             w_last_pix;
  logic             w_last_line;
  logic             w_bad;

  // In WAIT_SOF only the SOF beat is counted (as pixel 0); junk is ignored.
  always_comb begin
    w_active    = i_beat & (i_in_receive | (i_in_wait_sof & i_tuser));
    w_last_pix  = (r_pix_cnt == CNT_W'(IMG_WIDTH - 1));
    w_last_line = (r_line_cnt == CNT_W'(IMG_HEIGHT - 1));
    w_bad       = (i_tlast != w_last_pix) | (i_in_receive & i_tuser);
  end

  assign o_geom_err  = w_active & w_bad;
  assign o_frame_end = w_active & ~w_bad & w_last_pix & w_last_line;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_active && !w_bad) begin
      if (w_last_pix) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= w_last_line ? '0 : r_line_cnt + 1'b1;
      end else begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gradient_frame_sequencer.sv
// Frame-level admission controller in front of the Gx/Gy pipeline: admits one
// frame per start, checks geometry, waits for the output frame to drain.
//
//   state    | meaning
//   IDLE     | stream gated, waiting for i_start
//   WAIT_SOF | tready high, dropping beats until tuser
//   RECEIVE  | counting pixels/lines, checking tlast/tuser placement
//   DRAIN    | input gated, waiting for OUT_LINES output lines or timeout
//   DONE     | one-cycle completion pulse, frame counter bump
//   ERROR    | parked until i_abort or reset
module gradient_frame_sequencer
  import gradient_pkg::*;
#(
  parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
  parameter int OUT_LINES     = 3072,
  parameter int DRAIN_TIMEOUT = 65535,
  parameter int CNT_W         = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_continuous,
  input  logic                 i_abort,
  gradient_frame_sequencer_if.slave axis,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err_geom,
  output logic                 o_err_timeout,
  output logic [CNT_W-1:0]     o_frame_count,
  output logic [2:0]           o_state
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_tready;
  logic             r_busy;
  logic             r_done;
  logic             r_err_geom;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_out_line_cnt;
  logic [TMR_W-1:0] r_drain_tmr;

  logic w_in_beat;
  logic w_out_beat;
  logic w_out_line;
  logic w_timeout;
  logic w_clear;
  logic w_frame_end;
  logic w_geom_err;

  assign w_in_beat  = axis.s_axis_tvalid & r_tready;
  assign w_out_beat = axis.m_axis_tvalid;
  assign w_out_line = axis.m_axis_tvalid & axis.m_axis_tlast;
  assign w_timeout  = (r_state == S_DRAIN) & ~w_out_beat & (r_drain_tmr <= TMR_W'(1));

  gradient_geom_checker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .CNT_W      (CNT_W)
  ) u_geom (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_clear       (w_clear),
    .i_beat        (w_in_beat),
    .i_in_wait_sof (r_state == S_WAIT_SOF),
    .i_in_receive  (r_state == S_RECEIVE),
    .i_tuser       (axis.s_axis_tuser),
    .i_tlast       (axis.s_axis_tlast),
    .o_frame_end   (w_frame_end),
    .o_geom_err    (w_geom_err)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_WAIT_SOF;
      S_WAIT_SOF: begin
        if (w_geom_err)                          w_next = S_ERROR;
        else if (w_frame_end)                    w_next = S_DRAIN;
        else if (w_in_beat && axis.s_axis_tuser) w_next = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (w_geom_err)       w_next = S_ERROR;
        else if (w_frame_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_out_line_cnt >= CNT_W'(OUT_LINES)) w_next = S_DONE;
        else if (w_timeout)                      w_next = S_ERROR;
      end
      S_DONE:  w_next = i_continuous ? S_WAIT_SOF : S_IDLE;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end

  // Per-frame counters restart whenever a new frame is armed or on abort.
  assign w_clear = i_abort | ((w_next == S_WAIT_SOF) & (r_state != S_WAIT_SOF));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_tready       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err_geom     <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_frame_cnt    <= '0;
      r_out_line_cnt <= '0;
      r_drain_tmr    <= '0;
    end else begin
      r_state  <= w_next;
      r_tready <= (w_next == S_WAIT_SOF) || (w_next == S_RECEIVE);
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      if (w_next == S_DONE) r_frame_cnt <= r_frame_cnt + 1'b1;

      if (r_state == S_IDLE && i_start && !i_abort) begin
        r_err_geom    <= 1'b0;
        r_err_timeout <= 1'b0;
      end else if (w_next == S_ERROR) begin
        if (w_geom_err) r_err_geom    <= 1'b1;
        if (w_timeout)  r_err_timeout <= 1'b1;
      end

      if (w_clear)                              r_out_line_cnt <= '0;
      else if (r_state != S_IDLE && w_out_line) r_out_line_cnt <= r_out_line_cnt + 1'b1;

      // Down-counter of beat-free DRAIN cycles; any output beat reloads it.
      if (w_next == S_DRAIN) begin
        if (r_state != S_DRAIN || w_out_beat) r_drain_tmr <= TMR_W'(DRAIN_TIMEOUT);
        else if (r_drain_tmr != '0)           r_drain_tmr <= r_drain_tmr - 1'b1;
      end else begin
        r_drain_tmr <= '0;
      end
    end
  end

  assign axis.o_s_axis_tready = r_tready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_geom    = r_err_geom;
  assign o_err_timeout = r_err_timeout;
  assign o_frame_count = r_frame_cnt;
  assign o_state       = r_state;

endmodule
